// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants and the helper that sums the four timing segments.
// Downstream pixel stages import this package so everyone agrees on the geometry.
package vga_timing_pkg;

  localparam int POS_W       = 10;
  localparam int FRAME_CNT_W = 10;
  localparam int MAX_TOTAL   = 1 << POS_W;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;

  localparam bit VGA_H_SYNC_POL = 1'b0;
  localparam bit VGA_V_SYNC_POL = 1'b0;

  typedef logic [POS_W-1:0]       pos_t;
  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  localparam int VGA_H_TOTAL = axis_total(VGA_H_DISPLAY, VGA_H_FRONT, VGA_H_SYNC, VGA_H_BACK);
  localparam int VGA_V_TOTAL = axis_total(VGA_V_DISPLAY, VGA_V_FRONT, VGA_V_SYNC, VGA_V_BACK);

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle between the timing core (master) and the pixel renderer (slave).
// pix_en flows from the consumer side; everything else is produced by the core.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic       pix_en;
  logic       hsync;
  logic       vsync;
  logic       display_on;
  logic       line_start;
  logic       frame_start;
  pos_t       hpos;
  pos_t       vpos;
  frame_cnt_t frame_cnt;

  modport master (
    input  pix_en,
    output hsync, vsync, display_on, line_start, frame_start, hpos, vpos, frame_cnt
  );

  modport slave (
    output pix_en,
    input  hsync, vsync, display_on, line_start, frame_start, hpos, vpos, frame_cnt
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter plus sync/active flags registered from the next position,
// so the flags always describe the position presented alongside them.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = VGA_H_DISPLAY,
  parameter int FRONT   = VGA_H_FRONT,
  parameter int SYNC    = VGA_H_SYNC,
  parameter int BACK    = VGA_H_BACK,
  parameter bit POL     = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_adv,
  output pos_t o_pos,
  output logic o_wrap,
  output logic o_sync,
  output logic o_active
);

  localparam int TOTAL    = axis_total(DISPLAY, FRONT, SYNC, BACK);
  localparam int SYNC_BEG = DISPLAY + FRONT;
  localparam int SYNC_END = SYNC_BEG + SYNC;

  // One extra bit so a sync window ending exactly at 1024 still compares correctly.
  typedef logic [POS_W:0] cmp_t;

  pos_t r_pos;
  pos_t w_pos_nxt;
  logic r_sync;
  logic r_active;
  logic w_wrap;
  logic w_sync_nxt;
  logic w_active_nxt;

  assign w_wrap       = (r_pos == pos_t'(TOTAL - 1));
  assign w_pos_nxt    = w_wrap ? '0 : r_pos + pos_t'(1);
  assign w_sync_nxt   = ({1'b0, w_pos_nxt} >= cmp_t'(SYNC_BEG)) &&
                        ({1'b0, w_pos_nxt} <  cmp_t'(SYNC_END));
  assign w_active_nxt = ({1'b0, w_pos_nxt} <  cmp_t'(DISPLAY));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pos    <= '0;
      r_sync   <= ~POL;
      r_active <= 1'b1;
    end else if (i_adv) begin
      r_pos    <= w_pos_nxt;
      r_sync   <= w_sync_nxt ? POL : ~POL;
      r_active <= w_active_nxt;
    end
  end

  assign o_pos    = r_pos;
  assign o_wrap   = w_wrap;
  assign o_sync   = r_sync;
  assign o_active = r_active;

endmodule

// File: rtl/vga_timing_core.sv
// VGA raster timing generator: horizontal and vertical axis counters plus line/frame strobes
// and a free-running frame counter for animation logic.
module vga_timing_core
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = VGA_H_DISPLAY,
  parameter int H_FRONT    = VGA_H_FRONT,
  parameter int H_SYNC     = VGA_H_SYNC,
  parameter int H_BACK     = VGA_H_BACK,
  parameter int V_DISPLAY  = VGA_V_DISPLAY,
  parameter int V_FRONT    = VGA_V_FRONT,
  parameter int V_SYNC     = VGA_V_SYNC,
  parameter int V_BACK     = VGA_V_BACK,
  parameter bit H_SYNC_POL = VGA_H_SYNC_POL,
  parameter bit V_SYNC_POL = VGA_V_SYNC_POL
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  vga_timing_if.master io_vga
);

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_core: H_TOTAL/V_TOTAL must not exceed 1024");
  end

  pos_t       w_hpos;
  pos_t       w_vpos;
  logic       w_h_wrap;
  logic       w_v_wrap;
  logic       w_h_sync;
  logic       w_v_sync;
  logic       w_h_active;
  logic       w_v_active;
  logic       w_v_adv;
  logic       r_line_start;
  logic       r_frame_start;
  logic       r_started;
  frame_cnt_t r_frame_cnt;

  assign w_v_adv = io_vga.pix_en & w_h_wrap;

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(H_SYNC_POL)
  ) u_h_axis (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_adv    (io_vga.pix_en),
    .o_pos    (w_hpos),
    .o_wrap   (w_h_wrap),
    .o_sync   (w_h_sync),
    .o_active (w_h_active)
  );

  vga_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(V_SYNC_POL)
  ) u_v_axis (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_adv    (w_v_adv),
    .o_pos    (w_vpos),
    .o_wrap   (w_v_wrap),
    .o_sync   (w_v_sync),
    .o_active (w_v_active)
  );

  // r_started keeps display_on low from reset until the first pixel advance.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
      r_started     <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      r_line_start  <= w_v_adv;
      r_frame_start <= w_v_adv & w_v_wrap;
      if (w_v_adv & w_v_wrap) begin
        r_frame_cnt <= r_frame_cnt + frame_cnt_t'(1);
      end
      if (io_vga.pix_en) begin
        r_started <= 1'b1;
      end
    end
  end

  assign io_vga.hpos        = w_hpos;
  assign io_vga.vpos        = w_vpos;
  assign io_vga.hsync       = w_h_sync;
  assign io_vga.vsync       = w_v_sync;
  assign io_vga.display_on  = r_started & w_h_active & w_v_active;
  assign io_vga.line_start  = r_line_start;
  assign io_vga.frame_start = r_frame_start;
  assign io_vga.frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_core.sv
// Bench for vga_timing_core: a full-size instance exercised over a few lines and a tiny 12x7
// instance run through the 1023 -> 0 frame counter wrap; strobes are checked against queued expectations.
`timescale 1ns/1ps
module tb_vga_timing_core;
  import vga_timing_pkg::*;

  typedef struct {
    int vpos;
    int fc;
    int hlo;
    int hfirst;
    int de;
  } line_exp_t;

  typedef struct {
    int fc;
    int cyc;
    int lines;
    int vlo;
    int hlo;
    int de;
  } frame_exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n_a = 1'b0;
  logic rst_n_b = 1'b0;

  vga_timing_if vga_a();
  vga_timing_if vga_b();

  vga_timing_core u_dut_a (
    .i_clk   (clk),
    .i_rst_n (rst_n_a),
    .io_vga  (vga_a)
  );

  vga_timing_core #(
    .H_DISPLAY(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1)
  ) u_dut_b (
    .i_clk   (clk),
    .i_rst_n (rst_n_b),
    .io_vga  (vga_b)
  );

  int errors = 0;
  int checks = 0;

  line_exp_t  q_line[$];
  frame_exp_t q_frame[$];
  bit mon_a_on = 1'b0;
  bit mon_b_on = 1'b0;

  int a_hlo = 0, a_hfirst = -1, a_de = 0, viol_a = 0;
  int b_cyc = 0, b_lines = 0, b_vlo = 0, b_hlo = 0, b_de = 0, viol_b = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step_a(input bit en);
    vga_a.pix_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic step_b(input bit en);
    vga_b.pix_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_hpos"},        int'(vga_a.hpos), 0);
    chk({tag, "_vpos"},        int'(vga_a.vpos), 0);
    chk({tag, "_hsync"},       int'(vga_a.hsync), 1);
    chk({tag, "_vsync"},       int'(vga_a.vsync), 1);
    chk({tag, "_display_on"},  int'(vga_a.display_on), 0);
    chk({tag, "_line_start"},  int'(vga_a.line_start), 0);
    chk({tag, "_frame_start"}, int'(vga_a.frame_start), 0);
    chk({tag, "_frame_cnt"},   int'(vga_a.frame_cnt), 0);
  endtask

  task automatic chk_reset_b(input string tag);
    chk({tag, "_hpos"},        int'(vga_b.hpos), 0);
    chk({tag, "_vpos"},        int'(vga_b.vpos), 0);
    chk({tag, "_hsync"},       int'(vga_b.hsync), 1);
    chk({tag, "_vsync"},       int'(vga_b.vsync), 1);
    chk({tag, "_display_on"},  int'(vga_b.display_on), 0);
    chk({tag, "_frame_start"}, int'(vga_b.frame_start), 0);
    chk({tag, "_frame_cnt"},   int'(vga_b.frame_cnt), 0);
  endtask

  // Monitor A: per-line statistics, compared whenever a line_start strobe appears.
  initial begin : mon_a
    line_exp_t e;
    forever begin
      @(negedge clk);
      if (mon_a_on) begin
        if (vga_a.frame_start) chk("a_unexpected_frame_start", 1, 0);
        if (vga_a.line_start) begin
          if (q_line.size() == 0) begin
            chk("a_unexpected_line_start", 1, 0);
          end else begin
            e = q_line.pop_front();
            chk("a_line_hpos",   int'(vga_a.hpos), 0);
            chk("a_line_vpos",   int'(vga_a.vpos), e.vpos);
            chk("a_line_fcnt",   int'(vga_a.frame_cnt), e.fc);
            chk("a_hsync_width", a_hlo, e.hlo);
            chk("a_hsync_first", a_hfirst, e.hfirst);
            chk("a_display_cnt", a_de, e.de);
          end
          a_hlo = 0;
          a_hfirst = -1;
          a_de = 0;
        end
        if (!vga_a.hsync) begin
          if (a_hfirst < 0) a_hfirst = int'(vga_a.hpos);
          a_hlo++;
        end
        if (vga_a.display_on) begin
          a_de++;
          if (vga_a.hpos >= 10'd640 || vga_a.vpos >= 10'd480) viol_a++;
        end
      end
    end
  end

  // Monitor B: per-frame statistics, compared whenever a frame_start strobe appears.
  initial begin : mon_b
    frame_exp_t e;
    forever begin
      @(negedge clk);
      if (mon_b_on) begin
        b_cyc++;
        if (vga_b.line_start) b_lines++;
        if (!vga_b.vsync) b_vlo++;
        if (!vga_b.hsync) b_hlo++;
        if (vga_b.display_on) begin
          b_de++;
          if (vga_b.hpos >= 10'd8 || vga_b.vpos >= 10'd4) viol_b++;
        end
        if (vga_b.frame_start) begin
          if (q_frame.size() == 0) begin
            chk("b_unexpected_frame_start", 1, 0);
          end else begin
            e = q_frame.pop_front();
            chk("b_frame_cnt",   int'(vga_b.frame_cnt), e.fc);
            chk("b_frame_hpos",  int'(vga_b.hpos), 0);
            chk("b_frame_vpos",  int'(vga_b.vpos), 0);
            chk("b_frame_cyc",   b_cyc, e.cyc);
            chk("b_frame_lines", b_lines, e.lines);
            chk("b_vsync_width", b_vlo, e.vlo);
            chk("b_hsync_total", b_hlo, e.hlo);
            chk("b_display_cnt", b_de, e.de);
          end
          b_cyc = 0;
          b_lines = 0;
          b_vlo = 0;
          b_hlo = 0;
          b_de = 0;
        end
      end
    end
  end

  task automatic stim_a();
    rst_n_a = 1'b0;
    step_a(1'b1);
    step_a(1'b1);
    @(negedge clk);
    chk_reset_a("a_rst");
    rst_n_a = 1'b1;
    step_a(1'b1);
    mon_a_on = 1'b1;
    // Line 0 loses pixel (0,0) to the post-reset start at hpos=1.
    q_line.push_back('{1, 0, 96, 656, 639});
    q_line.push_back('{2, 0, 96, 656, 640});
    repeat (1599) step_a(1'b1);
    q_line.push_back('{3, 0, 192, 656, 1280});
    for (int i = 0; i < 1600; i++) step_a(i % 2 == 1);
    q_line.push_back('{4, 0, 96, 656, 690});
    repeat (50) step_a(1'b0);
    repeat (800) step_a(1'b1);
    repeat (700) step_a(1'b1);
    @(negedge clk);
    chk("a_mid_hpos",       int'(vga_a.hpos), 700);
    chk("a_mid_vpos",       int'(vga_a.vpos), 4);
    chk("a_mid_hsync",      int'(vga_a.hsync), 0);
    chk("a_mid_vsync",      int'(vga_a.vsync), 1);
    chk("a_mid_display_on", int'(vga_a.display_on), 0);
    mon_a_on = 1'b0;
    rst_n_a = 1'b0;
    step_a(1'b1);
    @(negedge clk);
    chk_reset_a("a_midrst");
    rst_n_a = 1'b1;
  endtask

  task automatic stim_b();
    rst_n_b = 1'b0;
    step_b(1'b1);
    step_b(1'b1);
    @(negedge clk);
    chk_reset_b("b_rst");
    rst_n_b = 1'b1;
    for (int f = 1; f <= 1025; f++) q_frame.push_back('{f % 1024, 84, 7, 12, 14, 32});
    step_b(1'b1);
    mon_b_on = 1'b1;
    repeat (1025 * 84 - 1) step_b(1'b1);
    repeat (69) step_b(1'b1);
    @(negedge clk);
    chk("b_mid_hpos",       int'(vga_b.hpos), 9);
    chk("b_mid_vpos",       int'(vga_b.vpos), 5);
    chk("b_mid_hsync",      int'(vga_b.hsync), 0);
    chk("b_mid_vsync",      int'(vga_b.vsync), 0);
    chk("b_mid_display_on", int'(vga_b.display_on), 0);
    mon_b_on = 1'b0;
    rst_n_b = 1'b0;
    step_b(1'b1);
    @(negedge clk);
    chk_reset_b("b_midrst");
    rst_n_b = 1'b1;
  endtask

  initial begin
    vga_a.pix_en = 1'b0;
    vga_b.pix_en = 1'b0;
    fork
      stim_a();
      stim_b();
    join
    repeat (2) @(posedge clk);
    chk("a_queue_drained",   q_line.size(), 0);
    chk("b_queue_drained",   q_frame.size(), 0);
    chk("a_display_outside", viol_a, 0);
    chk("b_display_outside", viol_b, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
